pcap_dma_buffer_table: RTL
==========================

// Module: pcap_dma_buffer_table
// PURPOSE
//  Parametrised DMA buffer-address table and IRQ status generator for position capture (PCAP).
//  Software preloads buffer addresses into a FIFO table; on arm the block presents addresses to the DMA engine.
//  It counts the samples written into each buffer, switches buffers on block-full and reports every event to software.
//  Events are reported as one IRQ pulse plus a 32-bit status word {SMPL_COUNT[15:0], 8'h00, IRQ_FLAGS[7:0]}.
// PARAMETERS
//  ADDR_W          32    width of a buffer address
//  DEPTH           32    table entries; power of 2, >=2
//  CNT_W           16    sample counter width; 1..16
//  TIMEOUT_CYCLES  1024  idle cycles before forced buffer close (only with PCAP_DMA_TIMEOUT_EN)
// PORTS
//  clk_i         in   1          system clock
//  resetn_i      in   1          asynchronous reset, active-low
//  addr_wr_i     in   1          push addr_i into the table
//  addr_i        in   ADDR_W     buffer address
//  flush_i       in   1          empty the table; honoured in IDLE only
//  blk_size_i    in   CNT_W      samples per buffer; sampled on arm and on each buffer switch; 0 treated as 1
//  arm_i         in   1          start capture (pulse)
//  disarm_i      in   1          abort capture (pulse)
//  sample_i      in   1          one sample written to the current buffer
//  end_i         in   1          capture finished (last sample)
//  irq_ack_i     in   1          software has read irq_status_o
//  dma_addr_o    out  ADDR_W     current buffer address
//  dma_valid_o   out  1          dma_addr_o is live (ACTIVE state)
//  armed_o       out  1          capture in progress
//  fill_o        out  log2(DEPTH)+1  table occupancy
//  irq_o         out  1          one-cycle event pulse
//  irq_status_o  out  32         {count, 8'h00, flags}
// BEHAVIOUR
//  Reset: all outputs and internal state 0; table empty; FSM in IDLE.
//  Table: FIFO. Push when full: entry dropped, sticky flag TBL_OVF set (reported in next event, then cleared).
//   Push and pop in the same cycle are both honoured, also when full.
//  FSM IDLE:
//   arm_i with fill>0: pop head into dma_addr_o, load blk_size, count=0 -> ACTIVE.
//    dma_valid_o=armed_o=1 the next cycle; event STARTED.
//   arm_i with empty table: event UNDERRUN; stay IDLE.
//  FSM ACTIVE:
//   sample_i increments count.
//   count reaching blk_size: event BUF_DONE with count=blk_size, count cleared.
//    Table non-empty: pop next address (visible next cycle); stay ACTIVE.
//    Table empty: also flag UNDERRUN -> IDLE.
//   end_i: event COMPLETE -> IDLE.
//   disarm_i: event DISARMED -> IDLE.
//   A sample_i in the same cycle is counted before end/disarm is evaluated.
//   Priority: disarm_i > end_i > block-full. arm_i and flush_i ignored.
//   A block-full coinciding with end/disarm merges BUF_DONE into the same event.
//  Leaving ACTIVE: dma_valid_o=armed_o=0 next cycle; remaining table entries kept.
//  Flags: 0 STARTED, 1 BUF_DONE, 2 COMPLETE, 3 DISARMED, 4 UNDERRUN, 5 TBL_OVF, 6 TIMEOUT, 7 LOST.
//  Events: irq_o pulses the cycle after the event; irq_status_o updates in that same cycle and holds.
//   irq_status_o[31:16] = count zero-extended.
//   pending flag: set by an event, cleared by irq_ack_i.
//   New event while pending: flags OR-merged, count replaced, LOST set.
//   Event in the same cycle as irq_ack_i: status replaced (no merge, no LOST); pending stays 1.
//  Reset mid-capture: immediate return to IDLE with the table emptied; no IRQ.
// CONFIGURATION
//  PCAP_DMA_TIMEOUT_EN defined:
//   in ACTIVE with count>0, TIMEOUT_CYCLES consecutive cycles without sample_i close the buffer early.
//   Event BUF_DONE|TIMEOUT with the partial count; buffer switch/underrun handled as for block-full.
//   The idle counter restarts on every sample_i and at each buffer switch.
//  PCAP_DMA_TIMEOUT_EN undefined: no idle counter; buffers close only on block-full, end or disarm.
//   Flag 6 is always 0.
// TESTING
//  1 Push A0,A1; blk=4; arm; 8 samples -> dma_addr A0 then A1; two irqs status 0x0004_0002 (second also 0x10).
//    FSM -> IDLE after the second irq.
//  2 Arm with empty table -> one irq, status 0x0000_0010, armed_o stays 0.
//  3 Push A0; blk=10; arm; 3 samples; sample_i+end_i same cycle -> status 0x0004_0004, armed_o=0.
//  4 DEPTH=4: push 5 addresses -> fill_o=4; next event has bit5 set.
//    Push+pop when full keeps fill_o=4.
//  5 No ack between STARTED and DISARMED (2 samples) -> status 0x0002_0089.
//    Ack in the same cycle as an event -> no LOST.
//  6 PCAP_DMA_TIMEOUT_EN, TIMEOUT_CYCLES=16: 2 samples then idle -> irq at cycle 16 after last sample.
//    Status 0x0002_0042; next address live. Macro undefined: no irq.

Source files
------------

// File: rtl/pcap_dma_buffer_table.sv
// PCAP DMA buffer-address table: FIFO of software-supplied buffer addresses, per-buffer sample
// counting, buffer switching and IRQ status reporting. Optional idle timeout via PCAP_DMA_TIMEOUT_EN.
module pcap_dma_buffer_table #(
  parameter int ADDR_W         = 32,
  parameter int DEPTH          = 32,
  parameter int CNT_W          = 16,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                       clk_i,
  input  logic                       resetn_i,
  input  logic                       addr_wr_i,
  input  logic [ADDR_W-1:0]          addr_i,
  input  logic                       flush_i,
  input  logic [CNT_W-1:0]           blk_size_i,
  input  logic                       arm_i,
  input  logic                       disarm_i,
  input  logic                       sample_i,
  input  logic                       end_i,
  input  logic                       irq_ack_i,
  output logic [ADDR_W-1:0]          dma_addr_o,
  output logic                       dma_valid_o,
  output logic                       armed_o,
  output logic [$clog2(DEPTH):0]     fill_o,
  output logic                       irq_o,
  output logic [31:0]                irq_status_o
);

  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = AW + 1;

  localparam int F_STARTED  = 0;
  localparam int F_BUF_DONE = 1;
  localparam int F_COMPLETE = 2;
  localparam int F_DISARMED = 3;
  localparam int F_UNDERRUN = 4;
  localparam int F_TBL_OVF  = 5;
  localparam int F_TIMEOUT  = 6;
  localparam int F_LOST     = 7;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   mem_q [DEPTH];
  logic [FILL_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d, blk_q, blk_d;
  logic                ovf_q, ovf_d;
  logic                pending_q, pending_d;
  logic                irq_q, irq_d;
  logic [7:0]          flags_q, flags_d;
  logic [CNT_W-1:0]    scnt_q, scnt_d;

  logic [FILL_W-1:0]   fill;
  logic                tbl_empty, tbl_full;
  logic [ADDR_W-1:0]   head;
  logic [CNT_W-1:0]    blk_eff, cnt_inc;
  logic                blk_full, timeout;
  logic                pop, push_ok, flush_do, ovf_now;
  logic                evt_vld;
  logic [7:0]          evt_flags;
  logic [CNT_W-1:0]    evt_cnt;

  assign fill      = wr_ptr_q - rd_ptr_q;
  assign tbl_empty = (fill == '0);
  assign tbl_full  = (fill == FILL_W'(DEPTH));
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign blk_eff   = (blk_size_i == '0) ? CNT_W'(1) : blk_size_i;
  assign cnt_inc   = cnt_q + CNT_W'(sample_i);
  assign blk_full  = (state_q == ACTIVE) && sample_i && (cnt_inc == blk_q);

`ifdef PCAP_DMA_TIMEOUT_EN
  localparam int IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_q, idle_d;

  // idle_q counts completed sample-free cycles of a partially filled buffer
  assign timeout = (state_q == ACTIVE) && (cnt_q != '0) && !sample_i &&
                   (idle_q == IW'(TIMEOUT_CYCLES - 1));

  always_comb begin
    idle_d = idle_q + IW'(1);
    if (state_q != ACTIVE || sample_i || cnt_q == '0 || timeout) idle_d = '0;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) idle_q <= '0;
    else           idle_q <= idle_d;
  end
`else
  // Never true for a legal parameter value; keeps the parameter referenced.
  assign timeout = (TIMEOUT_CYCLES < 0);
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    blk_d     = blk_q;
    addr_d    = addr_q;
    pop       = 1'b0;
    evt_vld   = 1'b0;
    evt_flags = '0;
    evt_cnt   = '0;
    case (state_q)
      IDLE: begin
        if (arm_i) begin
          evt_vld = 1'b1;
          if (!tbl_empty) begin
            pop                  = 1'b1;
            addr_d               = head;
            blk_d                = blk_eff;
            cnt_d                = '0;
            state_d              = ACTIVE;
            evt_flags[F_STARTED] = 1'b1;
          end else begin
            evt_flags[F_UNDERRUN] = 1'b1;
          end
        end
      end
      ACTIVE: begin
        cnt_d = cnt_inc;
        if (disarm_i || end_i) begin
          evt_vld               = 1'b1;
          evt_cnt               = cnt_inc;
          evt_flags[F_DISARMED] = disarm_i;
          evt_flags[F_COMPLETE] = !disarm_i;
          evt_flags[F_BUF_DONE] = blk_full;
          cnt_d                 = '0;
          state_d               = IDLE;
        end else if (blk_full || timeout) begin
          evt_vld               = 1'b1;
          evt_cnt               = cnt_inc;
          evt_flags[F_BUF_DONE] = 1'b1;
          evt_flags[F_TIMEOUT]  = timeout;
          cnt_d                 = '0;
          blk_d                 = blk_eff;
          if (!tbl_empty) begin
            pop    = 1'b1;
            addr_d = head;
          end else begin
            evt_flags[F_UNDERRUN] = 1'b1;
            state_d               = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A push into a full table survives only when a pop frees a slot in the same cycle
  assign flush_do = flush_i && (state_q == IDLE);
  assign push_ok  = addr_wr_i && (!tbl_full || pop) && !flush_do;
  assign ovf_now  = addr_wr_i && tbl_full && !pop && !flush_do;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush_do) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + FILL_W'(1);
      if (pop)     rd_ptr_d = rd_ptr_q + FILL_W'(1);
    end
    ovf_d = evt_vld ? 1'b0 : (ovf_q | ovf_now);
  end

  always_comb begin
    irq_d     = evt_vld;
    flags_d   = flags_q;
    scnt_d    = scnt_q;
    pending_d = pending_q & ~irq_ack_i;
    if (evt_vld) begin
      scnt_d    = evt_cnt;
      pending_d = 1'b1;
      if (pending_q && !irq_ack_i)
        flags_d = flags_q | evt_flags | (8'h01 << F_TBL_OVF) & {8{ovf_q | ovf_now}} | (8'h01 << F_LOST);
      else
        flags_d = evt_flags | ((8'h01 << F_TBL_OVF) & {8{ovf_q | ovf_now}});
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= addr_i;
  end

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q   <= IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      blk_q     <= '0;
      ovf_q     <= 1'b0;
      pending_q <= 1'b0;
      irq_q     <= 1'b0;
      flags_q   <= '0;
      scnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      addr_q    <= addr_d;
      cnt_q     <= cnt_d;
      blk_q     <= blk_d;
      ovf_q     <= ovf_d;
      pending_q <= pending_d;
      irq_q     <= irq_d;
      flags_q   <= flags_d;
      scnt_q    <= scnt_d;
    end
  end

  assign dma_addr_o   = addr_q;
  assign dma_valid_o  = (state_q == ACTIVE);
  assign armed_o      = (state_q == ACTIVE);
  assign fill_o       = fill;
  assign irq_o        = irq_q;
  assign irq_status_o = {16'(scnt_q), 8'h00, flags_q};

endmodule
